// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer: one shared 4-bit ripple adder processes
// a W-bit operation least significant nibble first, with valid/ready on both sides.

module four_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   sub,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic           carry;
  logic           sub_q;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [3:0]     add_b;
  logic [3:0]     add_s;
  logic           add_cout;
  logic           last;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign add_b    = sub_q ? ~b_sh[3:0] : b_sh[3:0];
  assign last     = (idx == IW'(NIBBLES - 1));

  four_adder u_add (
    .a    (a_sh[3:0]),
    .b    (add_b),
    .cin  (carry),
    .s    (add_s),
    .cout (add_cout)
  );

  // NOTE: operand shift registers are pure datapath, loaded before any use,
  // so they carry no reset; only control state and visible outputs are reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_sh  <= op_a;
      b_sh  <= op_b;
      sub_q <= sub;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 4;
      b_sh <= b_sh >> 4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= add_s;
          carry           <= add_cout;
          idx             <= idx + 1'b1;
          if (last) begin
            // Signed overflow uses the post-inversion B sign bit.
            cout      <= add_cout;
            ovf       <= (a_sh[3] == add_b[3]) && (add_s[3] != a_sh[3]);
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with a scoreboard queue of
// expected results computed from whole-word arithmetic.

module tb_nibble_serial_adder_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   r;
    bb     = s ? ~b : b;
    r      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : c)};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic c);
    int n;
    op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model(a, b, s, c));
  endtask

  // Waits for out_valid, checks latency and the scoreboard head.
  task automatic get_result(input bit scramble);
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (scramble) begin
        op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", out_valid, 1'b1);
    check("latency", lat, NIBBLES);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("sum", sum, e.sum);
      check("cout", cout, e.cout);
      check("ovf", ovf, e.ovf);
    end
  endtask

  task automatic handshake_done();
    @(posedge clk); #1;
    check("hs_out_valid_low", out_valid, 1'b0);
    check("hs_in_ready_high", in_ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;
    bit           saw_valid;

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_no_accept", busy, 1'b0);

    // Basic add, carry propagation, carry-in, overflow and subtraction cases.
    send(16'h1234, 16'h4321, 1'b0, 1'b0); get_result(0); handshake_done();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0); get_result(0); handshake_done();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1); get_result(0); handshake_done();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0); get_result(0); handshake_done();
    send(16'h0005, 16'h0007, 1'b1, 1'b1); get_result(0); handshake_done();
    send(16'h8000, 16'h0001, 1'b1, 1'b0); get_result(0); handshake_done();

    // Backpressure: result held while out_ready is low, new operands refused.
    out_ready = 1'b0;
    send(16'hA5A5, 16'h1111, 1'b0, 1'b1);
    get_result(0);
    held_sum = sum; held_cout = cout; held_ovf = ovf;
    op_a = 16'h0F0F; op_b = 16'h7001; sub = 1'b1; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_sum", sum, held_sum);
      check("bp_cout", cout, held_cout);
      check("bp_ovf", ovf, held_ovf);
    end
    out_ready = 1'b1;
    handshake_done();
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model(16'h0F0F, 16'h7001, 1'b1, 1'b0));
    check("bp_pending_accepted", busy, 1'b1);
    get_result(0); handshake_done();

    // Inputs toggled every cycle during RUN must not disturb the result.
    send(16'h1357, 16'h2468, 1'b1, 1'b0); get_result(1); handshake_done();
    send(16'h4000, 16'h3FFF, 1'b0, 1'b1); get_result(1); handshake_done();

    // Reset two edges into RUN discards the partial result.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_sum", sum, '0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_valid", saw_valid, 1'b0);
    send(16'h00FF, 16'h0001, 1'b0, 1'b0); get_result(0); handshake_done();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
